// File: rtl/seven_seg_scan_if.sv
// Bus between display-source logic and the seven_seg_scan driver.
// The master side supplies the shadow data; the slave side drives the display pins.
interface seven_seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic [DIGITS-1:0]     dp_in;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame;

  modport master (
    output load, din, dp_in,
    input  seg, dp, an, frame
  );

  modport slave (
    input  load, din, dp_in,
    output seg, dp, an, frame
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver: shadows a hex word, scans one digit per slot.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_BLANK_EN.
module seven_seg_scan #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int COMMON_ANODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  seven_seg_scan_if.slave bus
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam logic POL  = (COMMON_ANODE != 0);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SCAN_DIV - 1);

  logic [SLOT_W-1:0]   slot_reg;
  logic [IDX_W-1:0]    index_reg;
  logic [4*DIGITS-1:0] din_reg;
  logic [DIGITS-1:0]   dp_sh_reg;

  logic [6:0]          seg_reg, seg_next;
  logic                dp_reg, dp_next;
  logic [DIGITS-1:0]   an_reg, an_next;
  logic                frame_reg, frame_next;

  logic [3:0]          nibbles [DIGITS];
  logic [DIGITS-1:0]   blank_vec;
  logic [3:0]          cur_nib;
  logic [6:0]          glyph;
  logic [DIGITS-1:0]   an_hot;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nibbles[gi] = din_reg[4*gi +: 4];
`ifdef SEVEN_SEG_BLANK_EN
      // A digit is a leading zero only if it and every digit above it are zero.
      if (gi == 0) begin : g_lsd
        assign blank_vec[gi] = 1'b0;
      end else begin : g_upper
        assign blank_vec[gi] = (din_reg[4*DIGITS-1:4*gi] == '0);
      end
`else
      assign blank_vec[gi] = 1'b0;
`endif
    end
  endgenerate

  always_comb begin
    cur_nib = nibbles[index_reg];
    glyph   = 7'b0000000;
    case (cur_nib)
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1101111;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;
      4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;
      4'hF: glyph = 7'b1110001;
      default: glyph = 7'b0000000;
    endcase

    an_hot            = '0;
    an_hot[index_reg] = 1'b1;

    // Polarity is applied last so blanking and decode stay active-high internally.
    seg_next   = (blank_vec[index_reg] ? 7'b0000000 : glyph) ^ {7{POL}};
    dp_next    = dp_sh_reg[index_reg] ^ POL;
    an_next    = an_hot ^ {DIGITS{POL}};
    frame_next = (index_reg == '0) && (slot_reg == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg  <= '0;
      index_reg <= '0;
      din_reg   <= '0;
      dp_sh_reg <= '0;
      seg_reg   <= {7{POL}};
      dp_reg    <= POL;
      an_reg    <= {DIGITS{POL}};
      frame_reg <= 1'b0;
    end else begin
      if (bus.load) begin
        din_reg   <= bus.din;
        dp_sh_reg <= bus.dp_in;
      end

      if (slot_reg == LAST_SLOT) begin
        slot_reg  <= '0;
        index_reg <= (index_reg == LAST_IDX) ? '0 : index_reg + 1'b1;
      end else begin
        slot_reg  <= slot_reg + 1'b1;
      end

      // Outputs sample the pre-edge shadow, so a load shows one edge later.
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      an_reg    <= an_next;
      frame_reg <= frame_next;
    end
  end

  assign bus.seg   = seg_reg;
  assign bus.dp    = dp_reg;
  assign bus.an    = an_reg;
  assign bus.frame = frame_reg;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: one active-high and one common-anode instance.
// Blanking expectations follow SEVEN_SEG_BLANK_EN when it is defined for the build.
module tb_seven_seg_scan;

`ifdef SEVEN_SEG_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seven_seg_scan_if #(.DIGITS(4)) bus_a ();
  seven_seg_scan_if #(.DIGITS(4)) bus_b ();

  seven_seg_scan #(.DIGITS(4), .SCAN_DIV(4), .COMMON_ANODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  seven_seg_scan #(.DIGITS(4), .SCAN_DIV(4), .COMMON_ANODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_a.load = 1'b0;
    bus_b.load = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus_a.load = 1'b0; bus_a.din = '0; bus_a.dp_in = '0;
    bus_b.load = 1'b0; bus_b.din = '0; bus_b.dp_in = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_a.seg !== 7'b0000000) begin failures++; $display("FAIL reset_seg got=%b exp=%b", bus_a.seg, 7'b0000000); end
    checks++; if (bus_a.an !== 4'b0000) begin failures++; $display("FAIL reset_an got=%b exp=%b", bus_a.an, 4'b0000); end
    checks++; if (bus_a.dp !== 1'b0) begin failures++; $display("FAIL reset_dp got=%b exp=%b", bus_a.dp, 1'b0); end
    checks++; if (bus_a.frame !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=%b", bus_a.frame, 1'b0); end
    checks++; if (bus_b.seg !== 7'b1111111) begin failures++; $display("FAIL ca_reset_seg got=%b exp=%b", bus_b.seg, 7'b1111111); end
    checks++; if (bus_b.an !== 4'b1111) begin failures++; $display("FAIL ca_reset_an got=%b exp=%b", bus_b.an, 4'b1111); end
    checks++; if (bus_b.dp !== 1'b1) begin failures++; $display("FAIL ca_reset_dp got=%b exp=%b", bus_b.dp, 1'b1); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus_a.an !== 4'b0001) begin failures++; $display("FAIL first_an got=%b exp=%b", bus_a.an, 4'b0001); end
    checks++; if (bus_a.seg !== 7'b0111111) begin failures++; $display("FAIL first_seg got=%b exp=%b", bus_a.seg, 7'b0111111); end
    checks++; if (bus_a.frame !== 1'b1) begin failures++; $display("FAIL first_frame got=%b exp=%b", bus_a.frame, 1'b1); end
    checks++; if (bus_b.an !== 4'b1110) begin failures++; $display("FAIL ca_first_an got=%b exp=%b", bus_b.an, 4'b1110); end
    checks++; if (bus_b.seg !== 7'b1000000) begin failures++; $display("FAIL ca_first_seg got=%b exp=%b", bus_b.seg, 7'b1000000); end
    $display("test_reset done");
  endtask

  task automatic test_scan();
    logic [6:0] seg_tab [4];
    logic [3:0] an_exp;
    logic [6:0] seg_exp;
    logic       dp_exp, fr_exp;
    int         d;
    seg_tab[0] = 7'b1110001;
    seg_tab[1] = 7'b1110111;
    seg_tab[2] = 7'b1011011;
    seg_tab[3] = 7'b0000110;
    do_reset();
    bus_a.din = 16'h12AF; bus_a.dp_in = 4'b0100; bus_a.load = 1'b1;
    $display("load din=%h dp=%b", bus_a.din, bus_a.dp_in);
    tick();
    bus_a.load = 1'b0;
    for (int e = 2; e <= 17; e++) begin
      tick();
      d       = ((e - 1) / 4) % 4;
      an_exp  = 4'b0001 << d;
      seg_exp = seg_tab[d];
      dp_exp  = (d == 2);
      fr_exp  = ((e - 1) % 16 == 0);
      checks++; if (bus_a.an !== an_exp) begin failures++; $display("FAIL scan_an e=%0d got=%b exp=%b", e, bus_a.an, an_exp); end
      checks++; if (bus_a.seg !== seg_exp) begin failures++; $display("FAIL scan_seg e=%0d got=%b exp=%b", e, bus_a.seg, seg_exp); end
      checks++; if (bus_a.dp !== dp_exp) begin failures++; $display("FAIL scan_dp e=%0d got=%b exp=%b", e, bus_a.dp, dp_exp); end
      checks++; if (bus_a.frame !== fr_exp) begin failures++; $display("FAIL scan_frame e=%0d got=%b exp=%b", e, bus_a.frame, fr_exp); end
    end
    $display("test_scan done");
  endtask

  task automatic test_mid_slot_load();
    do_reset();
    tick();
    bus_a.din = 16'h0003; bus_a.dp_in = 4'b0000; bus_a.load = 1'b1;
    $display("load din=%h dp=%b", bus_a.din, bus_a.dp_in);
    tick();
    bus_a.load = 1'b0;
    checks++; if (bus_a.seg !== 7'b0111111) begin failures++; $display("FAIL midload_old_seg got=%b exp=%b", bus_a.seg, 7'b0111111); end
    checks++; if (bus_a.an !== 4'b0001) begin failures++; $display("FAIL midload_an2 got=%b exp=%b", bus_a.an, 4'b0001); end
    tick();
    checks++; if (bus_a.seg !== 7'b1001111) begin failures++; $display("FAIL midload_new_seg got=%b exp=%b", bus_a.seg, 7'b1001111); end
    checks++; if (bus_a.an !== 4'b0001) begin failures++; $display("FAIL midload_an3 got=%b exp=%b", bus_a.an, 4'b0001); end
    tick();
    checks++; if (bus_a.an !== 4'b0001) begin failures++; $display("FAIL midload_an4 got=%b exp=%b", bus_a.an, 4'b0001); end
    tick();
    checks++; if (bus_a.an !== 4'b0010) begin failures++; $display("FAIL midload_an5 got=%b exp=%b", bus_a.an, 4'b0010); end
    checks++; if (bus_a.frame !== 1'b0) begin failures++; $display("FAIL midload_frame got=%b exp=%b", bus_a.frame, 1'b0); end
  endtask

  task automatic test_polarity();
    logic [6:0] exp_d1;
    exp_d1 = BLANK ? 7'b1111111 : 7'b1000000;
    do_reset();
    bus_b.din = 16'h0008; bus_b.dp_in = 4'b0000; bus_b.load = 1'b1;
    $display("load(ca) din=%h dp=%b", bus_b.din, bus_b.dp_in);
    tick();
    bus_b.load = 1'b0;
    checks++; if (bus_b.dp !== 1'b1) begin failures++; $display("FAIL ca_dp got=%b exp=%b", bus_b.dp, 1'b1); end
    tick();
    checks++; if (bus_b.seg !== 7'b0000000) begin failures++; $display("FAIL ca_seg8 got=%b exp=%b", bus_b.seg, 7'b0000000); end
    checks++; if (bus_b.an !== 4'b1110) begin failures++; $display("FAIL ca_an0 got=%b exp=%b", bus_b.an, 4'b1110); end
    tick(); tick(); tick();
    checks++; if (bus_b.an !== 4'b1101) begin failures++; $display("FAIL ca_an1 got=%b exp=%b", bus_b.an, 4'b1101); end
    checks++; if (bus_b.seg !== exp_d1) begin failures++; $display("FAIL ca_seg_d1 got=%b exp=%b", bus_b.seg, exp_d1); end
  endtask

  task automatic test_blanking();
    logic [6:0] exp_up;
    exp_up = BLANK ? 7'b0000000 : 7'b0111111;
    do_reset();
    bus_a.din = 16'h0007; bus_a.dp_in = 4'b0000; bus_a.load = 1'b1;
    $display("load din=%h dp=%b", bus_a.din, bus_a.dp_in);
    tick();
    bus_a.load = 1'b0;
    tick();
    checks++; if (bus_a.seg !== 7'b0000111) begin failures++; $display("FAIL blank_d0 got=%b exp=%b", bus_a.seg, 7'b0000111); end
    tick(); tick();
    for (int d = 1; d <= 3; d++) begin
      tick(); tick(); tick(); tick();
      checks++; if (bus_a.seg !== exp_up) begin failures++; $display("FAIL blank_d%0d got=%b exp=%b", d, bus_a.seg, exp_up); end
    end
    do_reset();
    tick();
    checks++; if (bus_a.seg !== 7'b0111111) begin failures++; $display("FAIL blank_zero_d0 got=%b exp=%b", bus_a.seg, 7'b0111111); end
    tick(); tick(); tick(); tick();
    checks++; if (bus_a.seg !== exp_up) begin failures++; $display("FAIL blank_zero_d1 got=%b exp=%b", bus_a.seg, exp_up); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_a.din = 16'h0020; bus_a.dp_in = 4'b0000; bus_a.load = 1'b1;
    $display("load din=%h dp=%b", bus_a.din, bus_a.dp_in);
    tick();
    bus_a.load = 1'b0;
    tick(); tick(); tick();
    bus_a.din = 16'h0050; bus_a.load = 1'b1;
    $display("load din=%h dp=%b", bus_a.din, bus_a.dp_in);
    tick();
    bus_a.load = 1'b0;
    checks++; if (bus_a.an !== 4'b0010) begin failures++; $display("FAIL b2b_an5 got=%b exp=%b", bus_a.an, 4'b0010); end
    checks++; if (bus_a.seg !== 7'b1011011) begin failures++; $display("FAIL b2b_old_seg got=%b exp=%b", bus_a.seg, 7'b1011011); end
    tick();
    checks++; if (bus_a.seg !== 7'b1101101) begin failures++; $display("FAIL b2b_new_seg got=%b exp=%b", bus_a.seg, 7'b1101101); end
    checks++; if (bus_a.an !== 4'b0010) begin failures++; $display("FAIL b2b_an6 got=%b exp=%b", bus_a.an, 4'b0010); end
  endtask

  task automatic test_async_reset();
    logic [6:0] exp_up;
    exp_up = BLANK ? 7'b0000000 : 7'b0111111;
    do_reset();
    bus_a.din = 16'h12AF; bus_a.dp_in = 4'b0100; bus_a.load = 1'b1;
    $display("load din=%h dp=%b", bus_a.din, bus_a.dp_in);
    tick();
    bus_a.load = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (bus_a.an !== 4'b0100) begin failures++; $display("FAIL ar_pre_an got=%b exp=%b", bus_a.an, 4'b0100); end
    checks++; if (bus_a.dp !== 1'b1) begin failures++; $display("FAIL ar_pre_dp got=%b exp=%b", bus_a.dp, 1'b1); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_a.seg !== 7'b0000000) begin failures++; $display("FAIL ar_seg got=%b exp=%b", bus_a.seg, 7'b0000000); end
    checks++; if (bus_a.an !== 4'b0000) begin failures++; $display("FAIL ar_an got=%b exp=%b", bus_a.an, 4'b0000); end
    checks++; if (bus_a.dp !== 1'b0) begin failures++; $display("FAIL ar_dp got=%b exp=%b", bus_a.dp, 1'b0); end
    checks++; if (bus_b.an !== 4'b1111) begin failures++; $display("FAIL ar_ca_an got=%b exp=%b", bus_b.an, 4'b1111); end
    bus_a.din = 16'hFFFF; bus_a.load = 1'b1;
    tick();
    tick();
    bus_a.load = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (bus_a.an !== 4'b0001) begin failures++; $display("FAIL ar_restart_an got=%b exp=%b", bus_a.an, 4'b0001); end
    checks++; if (bus_a.seg !== 7'b0111111) begin failures++; $display("FAIL ar_restart_seg got=%b exp=%b", bus_a.seg, 7'b0111111); end
    checks++; if (bus_a.frame !== 1'b1) begin failures++; $display("FAIL ar_restart_frame got=%b exp=%b", bus_a.frame, 1'b1); end
    checks++; if (bus_a.dp !== 1'b0) begin failures++; $display("FAIL ar_restart_dp got=%b exp=%b", bus_a.dp, 1'b0); end
    tick(); tick(); tick(); tick();
    checks++; if (bus_a.seg !== exp_up) begin failures++; $display("FAIL ar_cleared_d1 got=%b exp=%b", bus_a.seg, exp_up); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mid_slot_load();
    test_polarity();
    test_blanking();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
